systolic_matmul_nxn: RTL and testbench

Parametrised N×N output-stationary systolic matrix-multiply engine with its own sequencing controller.
- Accepts unskewed operand beats: one column of A and one row of B per reduction step k.
- Skews operands internally, accumulates signed products in an N×N PE grid, then drains C = A·B one row at a time over a valid/ready port.
- Sits between the operand buffers and the result writeback in the accelerator datapath.

---
 rtl/systolic_matmul_nxn_if.sv | 34 +++
 rtl/systolic_matmul_nxn.sv | 217 +++++++++++++++++++++
 tb/tb_systolic_matmul_nxn.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/systolic_matmul_nxn_if.sv
// Operand/result bus of the N x N systolic matrix-multiply engine.
// The engine connects through the slave modport and the feeder/consumer through master.
interface systolic_matmul_nxn_if #(
   parameter int N            = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACCUM_WIDTH  = 32,
   parameter int K_MAX        = 255,
   parameter int KW           = $clog2(K_MAX + 1)
);
   logic                          start;
   logic [KW-1:0]                 k_len;
   logic                          busy;
   logic                          in_valid;
   logic                          in_ready;
   logic [N*DATA_WIDTH-1:0]       a_col;
   logic [N*WEIGHT_WIDTH-1:0]     b_row;
   logic                          out_valid;
   logic                          out_ready;
   logic [N*ACCUM_WIDTH-1:0]      out_row;
   logic [$clog2(N)-1:0]          out_row_idx;
   logic                          out_last;
   logic                          done;

   modport master (
      output start, k_len, in_valid, a_col, b_row, out_ready,
      input  busy, in_ready, out_valid, out_row, out_row_idx, out_last, done
   );

   modport slave (
      input  start, k_len, in_valid, a_col, b_row, out_ready,
      output busy, in_ready, out_valid, out_row, out_row_idx, out_last, done
   );
endinterface

// File: rtl/systolic_matmul_nxn.sv
// Output-stationary N x N systolic matmul: skews unskewed A-column/B-row beats,
// accumulates C = A*B in a PE grid, then drains C row by row over valid/ready.
module systolic_matmul_nxn_pe #(
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACCUM_WIDTH  = 32
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_arm,
   input  logic                           i_a_vld,
   input  logic                           i_b_vld,
   input  logic signed [DATA_WIDTH-1:0]   i_a,
   input  logic signed [WEIGHT_WIDTH-1:0] i_b,
   output logic signed [ACCUM_WIDTH-1:0]  o_acc
);
   localparam int PW = DATA_WIDTH + WEIGHT_WIDTH;

   logic signed [PW-1:0]          w_prod;
   logic signed [ACCUM_WIDTH-1:0] w_prod_x;
   logic signed [ACCUM_WIDTH-1:0] r_acc;
   logic                          r_first;

   assign w_prod   = PW'(i_a) * PW'(i_b);
   assign w_prod_x = ACCUM_WIDTH'(w_prod);
   assign o_acc    = r_acc;

   // First valid product of an operation overwrites, so no separate clear pass is needed
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_first <= 1'b0;
      end else if (i_arm) begin
         r_first <= 1'b1;
      end else if (i_a_vld && i_b_vld) begin
         r_acc   <= r_first ? w_prod_x : r_acc + w_prod_x;
         r_first <= 1'b0;
      end
   end
endmodule

module systolic_matmul_nxn #(
   parameter int N            = 4,
   parameter int DATA_WIDTH   = 16,
   parameter int WEIGHT_WIDTH = 8,
   parameter int ACCUM_WIDTH  = 32,
   parameter int K_MAX        = 255,
   parameter int KW           = $clog2(K_MAX + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   systolic_matmul_nxn_if.slave  bus
);
   localparam int RW  = $clog2(N);
   localparam int DCW = $clog2(2 * N);

   typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_OUTPUT} state_t;

   state_t            r_state, w_next;
   logic [KW-1:0]     r_klen, r_beats;
   logic [DCW-1:0]    r_drain;
   logic [RW-1:0]     r_row;
   logic              r_done;
   logic              w_arm, w_in_ready, w_accept, w_out_valid, w_row_last;

   logic [N-1:0][N-1:0][DATA_WIDTH-1:0]   w_pa;
   logic [N-1:0][N-1:0]                   w_pav;
   logic [N-1:0][N-1:0][WEIGHT_WIDTH-1:0] w_pb;
   logic [N-1:0][N-1:0]                   w_pbv;
   logic [N-1:0][N-1:0][ACCUM_WIDTH-1:0]  w_acc;

   assign w_in_ready  = (r_state == S_FEED) && (r_beats < r_klen);
   assign w_accept    = bus.in_valid && w_in_ready;
   assign w_out_valid = (r_state == S_OUTPUT);
   assign w_row_last  = (r_row == RW'(N - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_arm  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start && (bus.k_len != '0)) begin
               w_next = S_FEED;
               w_arm  = 1'b1;
            end
         end
         S_FEED:   if (w_accept && (r_beats == r_klen - 1'b1)) w_next = S_DRAIN;
         S_DRAIN:  if (r_drain == DCW'(2 * N - 2)) w_next = S_OUTPUT;
         S_OUTPUT: if (bus.out_ready && w_row_last) w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
   end

   // Drain holds until the far corner PE has taken its last operand one edge earlier
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_klen  <= '0;
         r_beats <= '0;
         r_drain <= '0;
         r_row   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_out_valid && bus.out_ready && w_row_last;
         case (r_state)
            S_IDLE: begin
               if (w_arm) begin
                  r_klen  <= bus.k_len;
                  r_beats <= '0;
               end
            end
            S_FEED: begin
               if (w_accept) r_beats <= r_beats + 1'b1;
               r_drain <= '0;
            end
            S_DRAIN:  r_drain <= r_drain + 1'b1;
            S_OUTPUT: if (bus.out_ready) r_row <= w_row_last ? '0 : r_row + 1'b1;
            default: ;
         endcase
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_skew
      if (i == 0) begin : g_a0
         assign w_pa[0][0]  = bus.a_col[0 +: DATA_WIDTH];
         assign w_pav[0][0] = w_accept;
         assign w_pb[0][0]  = bus.b_row[0 +: WEIGHT_WIDTH];
         assign w_pbv[0][0] = w_accept;
      end else begin : g_an
         logic [i-1:0][DATA_WIDTH-1:0]   r_ska;
         logic [i-1:0][WEIGHT_WIDTH-1:0] r_skb;
         logic [i-1:0]                   r_skv;
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_ska <= '0;
               r_skb <= '0;
               r_skv <= '0;
            end else begin
               r_ska[0] <= bus.a_col[i*DATA_WIDTH +: DATA_WIDTH];
               r_skb[0] <= bus.b_row[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
               r_skv[0] <= w_accept;
               for (int s = 1; s < i; s++) begin
                  r_ska[s] <= r_ska[s-1];
                  r_skb[s] <= r_skb[s-1];
                  r_skv[s] <= r_skv[s-1];
               end
            end
         end
         // Row i of A and column i of B share one skew depth
         assign w_pa[i][0]  = r_ska[i-1];
         assign w_pav[i][0] = r_skv[i-1];
         assign w_pb[0][i]  = r_skb[i-1];
         assign w_pbv[0][i] = r_skv[i-1];
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         if (j < N - 1) begin : g_ha
            logic [DATA_WIDTH-1:0] r_d;
            logic                  r_v;
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  r_d <= '0;
                  r_v <= 1'b0;
               end else begin
                  r_d <= w_pa[i][j];
                  r_v <= w_pav[i][j];
               end
            end
            assign w_pa[i][j+1]  = r_d;
            assign w_pav[i][j+1] = r_v;
         end
         if (i < N - 1) begin : g_hb
            logic [WEIGHT_WIDTH-1:0] r_d;
            logic                    r_v;
            always_ff @(posedge clk) begin
               if (!rst_n) begin
                  r_d <= '0;
                  r_v <= 1'b0;
               end else begin
                  r_d <= w_pb[i][j];
                  r_v <= w_pbv[i][j];
               end
            end
            assign w_pb[i+1][j]  = r_d;
            assign w_pbv[i+1][j] = r_v;
         end
         systolic_matmul_nxn_pe #(
            .DATA_WIDTH  (DATA_WIDTH),
            .WEIGHT_WIDTH(WEIGHT_WIDTH),
            .ACCUM_WIDTH (ACCUM_WIDTH)
         ) u_pe (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_arm  (w_arm),
            .i_a_vld(w_pav[i][j]),
            .i_b_vld(w_pbv[i][j]),
            .i_a    (w_pa[i][j]),
            .i_b    (w_pb[i][j]),
            .o_acc  (w_acc[i][j])
         );
      end
   end

   assign bus.busy        = (r_state != S_IDLE);
   assign bus.in_ready    = w_in_ready;
   assign bus.out_valid   = w_out_valid;
   assign bus.out_row     = w_out_valid ? w_acc[r_row] : '0;
   assign bus.out_row_idx = w_out_valid ? r_row : '0;
   assign bus.out_last    = w_out_valid && w_row_last;
   assign bus.done        = r_done;
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// Bench for systolic_matmul_nxn: directed and random operations against a plain
// matrix-product model, with one negedge process checking every presented row.
module tb_systolic_matmul_nxn;
   localparam int N  = 2;
   localparam int DW = 16;
   localparam int WW = 8;
   localparam int AW = 32;
   localparam int KM = 255;
   localparam int KW = $clog2(KM + 1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   systolic_matmul_nxn_if #(.N(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(AW), .K_MAX(KM)) bus ();
   systolic_matmul_nxn #(.N(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(AW), .K_MAX(KM))
      dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   systolic_matmul_nxn_if #(.N(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(16), .K_MAX(KM)) bus_w ();
   systolic_matmul_nxn #(.N(N), .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .ACCUM_WIDTH(16), .K_MAX(KM))
      dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int     ga [N][16];
   int     gb [16][N];
   longint q_c[$];
   int     q_i[$];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic longint wrap(input longint v, input int w);
      longint m, r;
      m = (longint'(1) << w);
      r = v & (m - 1);
      if (r >= (m >> 1)) r = r - m;
      return r;
   endfunction

   function automatic longint mm(input int i, input int j, input int k);
      longint s = 0;
      for (int kk = 0; kk < k; kk++) s += longint'(ga[i][kk]) * longint'(gb[kk][j]);
      return wrap(s, AW);
   endfunction

   // Row checker: every presented row is compared against the model queue
   logic [N*AW-1:0] prev_row;
   int   prev_idx;
   bit   prev_stall, prev_last_hs;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall   = 0;
         prev_last_hs = 0;
      end else begin
         bit last_hs;
         last_hs = 0;
         if (bus.done || prev_last_hs) chk("done_pulse", bus.done, prev_last_hs);
         if (bus.out_valid) begin
            if (prev_stall) begin
               chk("hold_row", bus.out_row == prev_row, 1);
               chk("hold_idx", bus.out_row_idx, prev_idx);
            end
            if (q_i.size() == 0) chk("row_expected", 0, 1);
            else begin
               for (int j = 0; j < N; j++) chk("c_elem", $signed(bus.out_row[j*AW +: AW]), q_c[j]);
               chk("row_idx", bus.out_row_idx, q_i[0]);
               chk("out_last", bus.out_last, q_i[0] == N - 1);
               if (bus.out_ready) begin
                  last_hs = (q_i[0] == N - 1);
                  repeat (N) void'(q_c.pop_front());
                  void'(q_i.pop_front());
               end
            end
         end
         prev_stall   = bus.out_valid && !bus.out_ready;
         prev_row     = bus.out_row;
         prev_idx     = bus.out_row_idx;
         prev_last_hs = last_hs;
      end
   end

   task automatic drive_beat(input int b);
      for (int i = 0; i < N; i++) bus.a_col[i*DW +: DW] = DW'(ga[i][b]);
      for (int j = 0; j < N; j++) bus.b_row[j*WW +: WW] = WW'(gb[b][j]);
   endtask

   // mode 0: always ready, 1: random ready, 2: 5-cycle stall on row 0 then toggling
   task automatic run_op(input int k, input int gap, input bit rnd_gap, input int mode);
      int last_acc, hs, vcnt, t, g;
      bit seen, dn;
      last_acc = 0; hs = 0; vcnt = 0; seen = 0; dn = 0;
      for (int r = 0; r < N; r++) begin
         for (int j = 0; j < N; j++) q_c.push_back(mm(r, j, k));
         q_i.push_back(r);
      end
      bus.start = 1'b1;
      bus.k_len = KW'(k);
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk("busy_after_start", bus.busy, 1);
      for (int b = 0; b < k; b++) begin
         g = rnd_gap ? int'($urandom_range(0, gap)) : ((b == 0) ? 0 : gap);
         bus.in_valid = 1'b0;
         repeat (g) begin @(posedge clk); #1; end
         drive_beat(b);
         bus.in_valid = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!bus.in_ready && t < 50);
         if (!bus.in_ready) chk("in_ready_timeout", 0, 1);
         @(posedge clk); #1;
         last_acc = cyc;
      end
      bus.in_valid = 1'b0;
      for (int it = 0; it < 300 && !dn; it++) begin
         case (mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = (vcnt < 5) ? 1'b0 : 1'(it & 1);
         endcase
         @(negedge clk);
         if (bus.out_valid && !seen) begin
            seen = 1;
            chk("latency", cyc - last_acc, 2 * N - 1);
         end
         if (seen) vcnt++;
         if (bus.out_valid && bus.out_ready) hs++;
         if (bus.done) begin
            dn = 1;
            chk("busy_at_done", bus.busy, 0);
            chk("valid_at_done", bus.out_valid, 0);
         end else begin
            @(posedge clk); #1;
         end
      end
      if (!dn) chk("done_timeout", 0, 1);
      chk("handshakes", hs, N);
   endtask

   task automatic load_t1();
      ga[0][0] = 1; ga[0][1] = 2; ga[1][0] = 3; ga[1][1] = 4;
      gb[0][0] = 5; gb[0][1] = 6; gb[1][0] = 7; gb[1][1] = 8;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      logic signed [DW-1:0] ra;
      logic signed [WW-1:0] rb;
      bus.start = 0; bus.k_len = '0; bus.in_valid = 0; bus.a_col = '0; bus.b_row = '0; bus.out_ready = 0;
      bus_w.start = 0; bus_w.k_len = '0; bus_w.in_valid = 0; bus_w.a_col = '0; bus_w.b_row = '0;
      bus_w.out_ready = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_out_last", bus.out_last, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_out_row", bus.out_row == '0, 1);
      chk("rst_out_row_idx", bus.out_row_idx, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // model pins for the hand-worked cases
      load_t1();
      chk("pin_c00", mm(0, 0, 2), 19);
      chk("pin_c01", mm(0, 1, 2), 22);
      chk("pin_c10", mm(1, 0, 2), 43);
      chk("pin_c11", mm(1, 1, 2), 50);
      run_op(2, 0, 0, 0);
      @(posedge clk); #1;
      run_op(2, 3, 0, 0);
      @(posedge clk); #1;

      ga[0][0] = -1; ga[0][1] = 2; ga[1][0] = 3; ga[1][1] = -4;
      gb[0][0] = -128; gb[0][1] = 127; gb[1][0] = 1; gb[1][1] = -1;
      chk("pin_s00", mm(0, 0, 2), 130);
      chk("pin_s01", mm(0, 1, 2), -129);
      chk("pin_s10", mm(1, 0, 2), -388);
      chk("pin_s11", mm(1, 1, 2), 385);
      run_op(2, 0, 0, 0);
      @(posedge clk); #1;

      load_t1();
      run_op(2, 0, 0, 2);
      @(posedge clk); #1;

      // back-to-back: next start lands on the done cycle
      load_t1();
      run_op(2, 0, 0, 0);
      for (int i = 0; i < N; i++) begin ga[i][0] = 1; gb[0][i] = 1; end
      run_op(1, 0, 0, 0);
      bus.start = 1'b1;
      bus.k_len = '0;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("k0_busy", bus.busy, 0);
      @(negedge clk);
      chk("k0_busy_later", bus.busy, 0);
      @(posedge clk); #1;

      // reset during FEED after one accepted beat
      load_t1();
      bus.start = 1'b1;
      bus.k_len = KW'(2);
      @(posedge clk); #1;
      bus.start = 1'b0;
      drive_beat(0);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_busy", bus.busy, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_done", bus.done, 0);
      @(posedge clk); #1;
      run_op(2, 0, 0, 0);
      @(posedge clk); #1;

      // random operands, gaps and backpressure
      for (int op = 0; op < 10; op++) begin
         int k;
         k = int'($urandom_range(1, 6));
         for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < N; i++) begin
               ra = DW'($urandom);
               rb = WW'($urandom);
               ga[i][kk] = ra;
               gb[kk][i] = rb;
            end
         run_op(k, 2, 1, 1);
         if (op[0]) begin @(posedge clk); #1; end
      end

      // 16-bit accumulator wraps modulo 2^16
      bus_w.start = 1'b1;
      bus_w.k_len = KW'(8);
      bus_w.a_col = {N{16'h007F}};
      bus_w.b_row = {N{8'h7F}};
      bus_w.in_valid = 1'b1;
      bus_w.out_ready = 1'b1;
      @(posedge clk); #1;
      bus_w.start = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!bus_w.out_valid && t < 100);
      if (!bus_w.out_valid) chk("wrap_timeout", 0, 1);
      for (int r = 0; r < N; r++) begin
         chk("wrap_idx", bus_w.out_row_idx, r);
         for (int j = 0; j < N; j++) chk("wrap_c", bus_w.out_row[j*16 +: 16], 63496);
         @(negedge clk);
      end
      chk("wrap_done", bus_w.done, 1);
      bus_w.in_valid = 1'b0;

      repeat (3) @(posedge clk);
      chk("queue_drained", q_i.size(), 0);
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
